pipeline_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage core.
- Generates the stall, flush, waiting, WFI, MRET and trap-take (p) controls consumed by the IF/ID, ID/EX and PC registers.
- Runs a small FSM that handles load-use stalls, branch flushes, memory wait, WFI sleep, interrupt entry and MRET return.
- Sits beside the PC/IF logic and fans its outputs out to every pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_hazard_detect.sv | 14 +
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SLEEP = 3'd1,
        TRAP  = 3'd2,
        RET   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [1:0] PCSEL_SEQ   = 2'd0;
    localparam logic [1:0] PCSEL_MTVEC = 2'd1;
    localparam logic [1:0] PCSEL_MEPC  = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the ID instruction.
module hazard_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       lu_hazard
);

    always_comb begin
        lu_hazard = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes, memory
// wait, WFI sleep, trap entry and MRET return for the 5-stage core.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            im_busy,
    input  logic            dm_busy,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_memread,
    input  logic            ex_br_taken,
    input  logic            id_wfi,
    input  logic            id_mret,
    input  logic            irq_pend,
    input  logic            irq_en,
    input  logic [XLEN-1:0] id_pc,
    output logic            stall,
    output logic            flush,
    output logic            idex_flush,
    output logic            waiting,
    output logic            wfi,
    output logic            mret,
    output logic            p,
    output logic [1:0]      pc_sel,
    output logic            mepc_we,
    output logic [XLEN-1:0] mepc_val,
    output logic [2:0]      state_o
);

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYC - 1);

    state_t            state, state_next;
    logic [2:0]        cnt, cnt_next;
    logic [XLEN-1:0]   mepc_q, mepc_next;
    logic              lu_hazard;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .lu_hazard  (lu_hazard)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            cnt    <= '0;
            mepc_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            mepc_q <= mepc_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mepc_next  = mepc_q;
        stall      = 1'b0;
        flush      = 1'b0;
        idex_flush = 1'b0;
        wfi        = 1'b0;
        mret       = 1'b0;
        p          = 1'b0;
        pc_sel     = PCSEL_SEQ;
        mepc_we    = 1'b0;
        waiting    = im_busy | dm_busy;

        if (waiting) begin
            wfi = (state == SLEEP);
        end else begin
            unique case (state)
                // MRET alongside a taken branch still returns; pc_sel = mepc overrides the branch.
                RUN: begin
                    if (irq_pend && irq_en) begin
                        state_next = TRAP;
                        mepc_next  = id_pc;
                    end else if (id_mret) begin
                        state_next = RET;
                    end else if (ex_br_taken) begin
                        flush      = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu_hazard) begin
                        stall      = 1'b1;
                        idex_flush = 1'b1;
                    end else if (id_wfi) begin
                        state_next = SLEEP;
                        idex_flush = 1'b1;
                    end
                end
                SLEEP: begin
                    wfi   = 1'b1;
                    flush = 1'b1;
                    if (irq_pend) begin
                        if (irq_en) begin
                            state_next = TRAP;
                            mepc_next  = id_pc + XLEN'(4);
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                TRAP: begin
                    p          = 1'b1;
                    pc_sel     = PCSEL_MTVEC;
                    mepc_we    = 1'b1;
                    flush      = 1'b1;
                    idex_flush = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (FLUSH_CYC == 1) ? RUN : HOLD;
                end
                RET: begin
                    mret       = 1'b1;
                    pc_sel     = PCSEL_MEPC;
                    flush      = 1'b1;
                    idex_flush = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (FLUSH_CYC == 1) ? RUN : HOLD;
                end
                HOLD: begin
                    flush    = 1'b1;
                    cnt_next = cnt - 3'd1;
                    if (cnt == 3'd1) state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end

        // Outputs read as all-zero for the whole time reset is asserted.
        if (!rst) begin
            stall      = 1'b0;
            flush      = 1'b0;
            idex_flush = 1'b0;
            waiting    = 1'b0;
            wfi        = 1'b0;
            mret       = 1'b0;
            p          = 1'b0;
            pc_sel     = PCSEL_SEQ;
            mepc_we    = 1'b0;
        end
    end

    assign mepc_val = mepc_q;
    assign state_o  = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; expected vectors are hand-derived per scenario.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_busy, dm_busy;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_br_taken, id_wfi, id_mret, irq_pend, irq_en;
    logic [31:0] id_pc;
    logic        stall, flush, idex_flush, waiting, wfi, mret, p, mepc_we;
    logic [1:0]  pc_sel;
    logic [31:0] mepc_val;
    logic [2:0]  state_o;

    int tests  = 0;
    int failed = 0;

    // {stall,flush,idex_flush,waiting, wfi,mret,p,mepc_we, pc_sel, state}
    logic [12:0] obs;
    assign obs = {stall, flush, idex_flush, waiting, wfi, mret, p, mepc_we, pc_sel, state_o};

    localparam logic [12:0] O_IDLE   = 13'b0000_0000_00_000;
    localparam logic [12:0] O_LU     = 13'b1010_0000_00_000;
    localparam logic [12:0] O_BR     = 13'b0110_0000_00_000;
    localparam logic [12:0] O_WFIIN  = 13'b0010_0000_00_000;
    localparam logic [12:0] O_SLEEP  = 13'b0100_1000_00_001;
    localparam logic [12:0] O_TRAP   = 13'b0110_0011_01_010;
    localparam logic [12:0] O_RET    = 13'b0110_0100_10_011;
    localparam logic [12:0] O_HOLD   = 13'b0100_0000_00_100;
    localparam logic [12:0] O_WTRAP  = 13'b0001_0000_00_010;
    localparam logic [12:0] O_WSLEEP = 13'b0001_1000_00_001;

    pipeline_ctrl #(.FLUSH_CYC(2), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .im_busy     (im_busy),
        .dm_busy     (dm_busy),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_br_taken (ex_br_taken),
        .id_wfi      (id_wfi),
        .id_mret     (id_mret),
        .irq_pend    (irq_pend),
        .irq_en      (irq_en),
        .id_pc       (id_pc),
        .stall       (stall),
        .flush       (flush),
        .idex_flush  (idex_flush),
        .waiting     (waiting),
        .wfi         (wfi),
        .mret        (mret),
        .p           (p),
        .pc_sel      (pc_sel),
        .mepc_we     (mepc_we),
        .mepc_val    (mepc_val),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        im_busy = 0; dm_busy = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_memread = 0; ex_br_taken = 0; id_wfi = 0; id_mret = 0;
        irq_pend = 0; irq_en = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        id_pc = 32'h0;
        im_busy = 1;
        #3;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL reset_outs got %b want %b", obs, O_IDLE); end
        tests++;
        if (mepc_val !== 32'h0) begin failed++; $display("FAIL reset_mepc got %h want %h", mepc_val, 32'h0); end
        im_busy = 0;
        @(negedge clk) rst = 1;
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL reset_release got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_load_use();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 0;
        #1;
        tests++;
        if (obs !== O_LU) begin failed++; $display("FAIL lu_rs2 got %b want %b", obs, O_LU); end
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL lu_after got %b want %b", obs, O_IDLE); end
        ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_rs1 = 0;
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL lu_x0 got %b want %b", obs, O_IDLE); end
        ex_rd = 7; id_rs1 = 7; id_rs2 = 3;
        #1;
        tests++;
        if (obs !== O_LU) begin failed++; $display("FAIL lu_rs1 got %b want %b", obs, O_LU); end
        ex_memread = 0;
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL lu_noload got %b want %b", obs, O_IDLE); end
        clear_inputs();
        step();
    endtask

    task automatic test_branch_vs_lu();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; ex_br_taken = 1;
        #1;
        tests++;
        if (obs !== O_BR) begin failed++; $display("FAIL br_lu got %b want %b", obs, O_BR); end
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL br_lu_state got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_mret();
        id_pc = 32'h100; id_mret = 1; ex_br_taken = 1;
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL mret_run got %b want %b", obs, O_IDLE); end
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_RET) begin failed++; $display("FAIL mret_ret got %b want %b", obs, O_RET); end
        step();
        irq_pend = 1; irq_en = 1;
        #1;
        tests++;
        if (obs !== O_HOLD) begin failed++; $display("FAIL mret_hold got %b want %b", obs, O_HOLD); end
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL mret_run_irq got %b want %b", obs, O_IDLE); end
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_TRAP) begin failed++; $display("FAIL mret_irq_trap got %b want %b", obs, O_TRAP); end
        tests++;
        if (mepc_val !== 32'h100) begin failed++; $display("FAIL mret_irq_mepc got %h want %h", mepc_val, 32'h100); end
        step();
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL mret_back_run got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_priority();
        id_pc = 32'h140; id_mret = 1; irq_pend = 1; irq_en = 1; ex_br_taken = 1; id_wfi = 1;
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_TRAP) begin failed++; $display("FAIL irq_beats_mret got %b want %b", obs, O_TRAP); end
        step();
        step();
        irq_pend = 1; irq_en = 0; ex_br_taken = 1;
        #1;
        tests++;
        if (obs !== O_BR) begin failed++; $display("FAIL irq_masked_br got %b want %b", obs, O_BR); end
        step();
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL irq_masked_state got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_wfi();
        id_pc = 32'h200; id_wfi = 1;
        #1;
        tests++;
        if (obs !== O_WFIIN) begin failed++; $display("FAIL wfi_enter got %b want %b", obs, O_WFIIN); end
        step();
        id_wfi = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin irq_pend = 1; irq_en = 1; end
            #1;
            tests++;
            if (obs !== O_SLEEP) begin failed++; $display("FAIL wfi_sleep[%0d] got %b want %b", i, obs, O_SLEEP); end
            step();
        end
        clear_inputs();
        #1;
        tests++;
        if (obs !== O_TRAP) begin failed++; $display("FAIL wfi_trap got %b want %b", obs, O_TRAP); end
        tests++;
        if (mepc_val !== 32'h204) begin failed++; $display("FAIL wfi_mepc got %h want %h", mepc_val, 32'h204); end
        step();
        tests++;
        if (obs !== O_HOLD) begin failed++; $display("FAIL wfi_hold got %b want %b", obs, O_HOLD); end
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL wfi_run got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_sleep_noen();
        id_pc = 32'h280; id_wfi = 1;
        step();
        id_wfi = 0; im_busy = 1;
        #1;
        tests++;
        if (obs !== O_WSLEEP) begin failed++; $display("FAIL sleep_wait got %b want %b", obs, O_WSLEEP); end
        im_busy = 0; irq_pend = 1; irq_en = 0;
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL sleep_wake_noen got %b want %b", obs, O_IDLE); end
        tests++;
        if (mepc_val !== 32'h204) begin failed++; $display("FAIL sleep_noen_mepc got %h want %h", mepc_val, 32'h204); end
        clear_inputs();
    endtask

    task automatic test_wait_trap();
        id_pc = 32'h300; irq_pend = 1; irq_en = 1;
        step();
        clear_inputs();
        dm_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (obs !== O_WTRAP) begin failed++; $display("FAIL wait_trap[%0d] got %b want %b", i, obs, O_WTRAP); end
            step();
        end
        dm_busy = 0;
        #1;
        tests++;
        if (obs !== O_TRAP) begin failed++; $display("FAIL wait_trap_release got %b want %b", obs, O_TRAP); end
        tests++;
        if (mepc_val !== 32'h300) begin failed++; $display("FAIL wait_trap_mepc got %h want %h", mepc_val, 32'h300); end
        step();
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL wait_trap_run got %b want %b", obs, O_IDLE); end
    endtask

    task automatic test_reset_sleep();
        id_pc = 32'h400; id_wfi = 1;
        step();
        id_wfi = 0;
        #1;
        tests++;
        if (obs !== O_SLEEP) begin failed++; $display("FAIL rst_sleep_pre got %b want %b", obs, O_SLEEP); end
        #1 rst = 0;
        #1;
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL rst_sleep_async got %b want %b", obs, O_IDLE); end
        @(negedge clk) rst = 1;
        step();
        tests++;
        if (obs !== O_IDLE) begin failed++; $display("FAIL rst_sleep_after got %b want %b", obs, O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_lu();
        test_mret();
        test_priority();
        test_wfi();
        test_sleep_noen();
        test_wait_trap();
        test_reset_sleep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
